// File: rtl/ram_sdp_clr.sv
// Single-clock simple-dual-port RAM with per-bit write mask, selectable
// read-during-write behaviour, optional output register, read-valid tracking
// and a clear engine that zeroes the array after reset or on request.
module ram_sdp_clr #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 1 << ADDR_W,
   parameter int RD_REG     = 0,
   parameter int RDW_MODE   = 0,
   parameter int CLR_ON_RST = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   output logic              busy_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0] wr_mask_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o
);

   // One extra counter bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   cnt_q;
   logic              init_done_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_in_range, rd_in_range;
   logic              wr_ok, rd_ok, rdw_hit;
   logic [DATA_W-1:0] wr_word, rd_word;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   // State register, clear address counter and the post-reset marker.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_done_q <= 1'b1;
         if (state_q == S_CLEAR)
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // Next state: start on request or on the first cycle after reset release.
   // NOTE: every variable written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (clr_i || (CLR_ON_RST != 0 && !init_done_q)) state_d = S_CLEAR;
         S_CLEAR: if (cnt_q == CNT_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs of the clear FSM: busy flag and port acceptance (ports dropped while clearing).
   always_comb begin
      busy_o = (state_q == S_CLEAR);
      wr_ok  = (state_q == S_IDLE) && wr_en_i && wr_in_range;
      rd_ok  = (state_q == S_IDLE) && rd_en_i;
   end

   assign wr_in_range = {1'b0, wr_addr_i} < DEPTH_L;
   assign rd_in_range = {1'b0, rd_addr_i} < DEPTH_L;
   assign wr_word     = (mem[wr_addr_i] & ~wr_mask_i) | (wr_data_i & wr_mask_i);
   assign rdw_hit     = (RDW_MODE != 0) && wr_ok && (wr_addr_i == rd_addr_i);

   // Array write port: the clear engine has priority over user writes.
   // NOTE: the array is deliberately not reset; only the clear engine zeroes it.
   always_ff @(posedge clk_i) begin
      if (state_q == S_CLEAR)
         mem[cnt_q[ADDR_W-1:0]] <= '0;
      else if (wr_ok)
         mem[wr_addr_i] <= wr_word;
   end

   // Read word selection: out-of-range reads give zero, same-address bypass in new-data mode.
   always_comb begin
      rd_word = '0;
      if (rd_in_range)
         rd_word = rdw_hit ? wr_word : mem[rd_addr_i];
   end

   // First read stage: data captured only on an accepted read, so it holds between reads.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_ok;
         if (rd_ok)
            rd_data_q <= rd_word;
      end
   end

   if (RD_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] out_data_q;
      logic              out_valid_q;

      // Optional output register adds one cycle of latency.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q)
               out_data_q <= rd_data_q;
         end
      end

      assign rd_data_o  = out_data_q;
      assign rd_valid_o = out_valid_q;
   end else begin : g_no_out_reg
      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
   end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: two instances (256 words / latency 1 / old-data, and
// 200 words / latency 2 / new-data) checked against an array model.
module tb_ram_sdp_clr;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]      clr, wr_en, rd_en;
   logic [1:0][7:0] wr_addr, wr_data, wr_mask, rd_addr;
   wire  [1:0]      busy, rd_valid;
   wire  [1:0][7:0] rd_data;

   int n_vec = 0;
   int n_err = 0;

   int dep [2] = '{256, 200};
   int lat [2] = '{1, 2};
   int rdw [2] = '{0, 1};

   logic [7:0] mem_m  [2][256];
   logic [7:0] last_d [2];

   typedef struct {
      logic       we;
      logic [7:0] wa, wd, wm;
      logic       re;
      logic [7:0] ra, ed;
   } step_t;

   ram_sdp_clr #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_REG(0), .RDW_MODE(0), .CLR_ON_RST(1)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .busy_o(busy[0]),
      .wr_en_i(wr_en[0]), .wr_addr_i(wr_addr[0]), .wr_data_i(wr_data[0]), .wr_mask_i(wr_mask[0]),
      .rd_en_i(rd_en[0]), .rd_addr_i(rd_addr[0]), .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]));

   ram_sdp_clr #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_REG(1), .RDW_MODE(1), .CLR_ON_RST(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .busy_o(busy[1]),
      .wr_en_i(wr_en[1]), .wr_addr_i(wr_addr[1]), .wr_data_i(wr_data[1]), .wr_mask_i(wr_mask[1]),
      .rd_en_i(rd_en[1]), .rd_addr_i(rd_addr[1]), .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]));

   // ---------------- model and stimulus helpers ----------------
   function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] d, input logic [7:0] m);
      return (old & ~m) | (d & m);
   endfunction

   function automatic logic [7:0] model_rd(input int k, input logic [7:0] a);
      if (int'(a) < dep[k]) return mem_m[k][a];
      return 8'h00;
   endfunction

   task automatic model_wr(input int k, input logic [7:0] a, input logic [7:0] d, input logic [7:0] m);
      if (int'(a) < dep[k]) mem_m[k][a] = merge(mem_m[k][a], d, m);
   endtask

   task automatic model_zero(input int k);
      for (int a = 0; a < 256; a++) mem_m[k][a] = 8'h00;
   endtask

   task automatic drive(input int k, input logic we, input logic [7:0] wa, input logic [7:0] wd,
                        input logic [7:0] wm, input logic re, input logic [7:0] ra);
      wr_en[k] = we; wr_addr[k] = wa; wr_data[k] = wd; wr_mask[k] = wm;
      rd_en[k] = re; rd_addr[k] = ra;
   endtask

   task automatic idle_all();
      clr = '0;
      for (int k = 0; k < 2; k++) drive(k, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_all();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_vec++; if (busy[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
         n_vec++; if (rd_valid[k] !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", k, rd_valid[k]); end
         n_vec++; if (rd_data[k] !== 8'h00) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 00", k, rd_data[k]); end
         last_d[k] = 8'h00;
      end
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_vec++; if (busy[k] !== 1'b0) begin n_err++; $display("FAIL release_busy[%0d]: got %b want 0", k, busy[k]); end
      end
   endtask

   // Called right after reset release; busy must rise on the first edge and stay up DEPTH cycles.
   task automatic test_clear_timing(input string tag);
      int cnt [2]; int first [2]; logic done [2]; int cyc;
      cnt = '{0, 0}; first = '{-1, -1}; done = '{1'b0, 1'b0}; cyc = 0;
      while (!(done[0] && done[1]) && cyc < 700) begin
         @(negedge clk); cyc++;
         for (int k = 0; k < 2; k++) begin
            if (!done[k]) begin
               if (busy[k]) begin if (first[k] < 0) first[k] = cyc; cnt[k]++; end
               else if (first[k] >= 0) done[k] = 1'b1;
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         n_vec++; if (!done[k]) begin n_err++; $display("FAIL %s_timeout[%0d]: busy never completed", tag, k); end
         n_vec++; if (first[k] != 1) begin n_err++; $display("FAIL %s_start[%0d]: busy rose at cycle %0d want 1", tag, k, first[k]); end
         n_vec++; if (cnt[k] != dep[k]) begin n_err++; $display("FAIL %s_len[%0d]: busy %0d cycles want %0d", tag, k, cnt[k], dep[k]); end
         model_zero(k);
      end
   endtask

   // mode 0: read every address 0..n-1 back to back; mode 1: random mixed writes/reads.
   task automatic test_stream(input int k, input int mode, input int n);
      logic ev [512]; logic [7:0] ed [512];
      logic we, re, expv; logic [7:0] wa, wd, wm, ra;
      int nr, pulses;
      nr = 0; pulses = 0;
      for (int i = 0; i < n + lat[k]; i++) begin
         @(negedge clk);
         expv = (i >= lat[k]) ? ev[i - lat[k]] : 1'b0;
         if (expv) last_d[k] = ed[i - lat[k]];
         if (rd_valid[k]) pulses++;
         n_vec++; if (rd_valid[k] !== expv) begin n_err++; $display("FAIL stream%0d_valid[%0d] step %0d: got %b want %b", mode, k, i, rd_valid[k], expv); end
         n_vec++; if (rd_data[k] !== last_d[k]) begin n_err++; $display("FAIL stream%0d_data[%0d] step %0d: got %h want %h", mode, k, i, rd_data[k], last_d[k]); end
         if (i < n) begin
            if (mode == 0) begin
               we = 1'b0; wa = 8'h00; wd = 8'h00; wm = 8'h00; re = 1'b1; ra = 8'(i);
            end else begin
               we = 1'($urandom_range(0, 1)); wa = 8'($urandom); wd = 8'($urandom);
               wm = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
               re = ($urandom_range(0, 3) != 0);
               ra = ($urandom_range(0, 1) == 1) ? wa : 8'($urandom);
            end
            ev[i] = re;
            if (rdw[k] != 0 && we && wa == ra) ed[i] = (int'(wa) < dep[k]) ? merge(mem_m[k][wa], wd, wm) : 8'h00;
            else ed[i] = model_rd(k, ra);
            if (re) nr++;
            if (we) model_wr(k, wa, wd, wm);
            drive(k, we, wa, wd, wm, re, ra);
         end else begin
            drive(k, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
         end
      end
      n_vec++; if (pulses != nr) begin n_err++; $display("FAIL stream%0d_pulses[%0d]: got %0d want %0d", mode, k, pulses, nr); end
   endtask

   task automatic test_write_read(input int k);
      step_t s [3];
      logic expv;
      s[0] = '{1'b1, 8'h10, 8'hA5, 8'hFF, 1'b0, 8'h00, 8'h00};
      s[1] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h10, 8'hA5};
      s[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
      for (int i = 0; i < 3 + lat[k]; i++) begin
         @(negedge clk);
         expv = 1'b0;
         if (i >= lat[k] && i - lat[k] < 3) begin expv = s[i - lat[k]].re; if (expv) last_d[k] = s[i - lat[k]].ed; end
         n_vec++; if (rd_valid[k] !== expv) begin n_err++; $display("FAIL wr_rd_valid[%0d] step %0d: got %b want %b", k, i, rd_valid[k], expv); end
         n_vec++; if (rd_data[k] !== last_d[k]) begin n_err++; $display("FAIL wr_rd_data[%0d] step %0d: got %h want %h", k, i, rd_data[k], last_d[k]); end
         if (i < 3) drive(k, s[i].we, s[i].wa, s[i].wd, s[i].wm, s[i].re, s[i].ra);
         else drive(k, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      end
      mem_m[k][8'h10] = 8'hA5;
   endtask

   task automatic test_rdw(input int k);
      step_t s [4];
      logic expv;
      s[0] = '{1'b1, 8'h20, 8'h0F, 8'hFF, 1'b0, 8'h00, 8'h00};
      s[1] = '{1'b1, 8'h20, 8'hF0, 8'hF0, 1'b1, 8'h20, (rdw[k] != 0) ? 8'hFF : 8'h0F};
      s[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h20, 8'hFF};
      s[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
      for (int i = 0; i < 4 + lat[k]; i++) begin
         @(negedge clk);
         expv = 1'b0;
         if (i >= lat[k] && i - lat[k] < 4) begin expv = s[i - lat[k]].re; if (expv) last_d[k] = s[i - lat[k]].ed; end
         n_vec++; if (rd_valid[k] !== expv) begin n_err++; $display("FAIL rdw_valid[%0d] step %0d: got %b want %b", k, i, rd_valid[k], expv); end
         n_vec++; if (rd_data[k] !== last_d[k]) begin n_err++; $display("FAIL rdw_data[%0d] step %0d: got %h want %h", k, i, rd_data[k], last_d[k]); end
         if (i < 4) drive(k, s[i].we, s[i].wa, s[i].wd, s[i].wm, s[i].re, s[i].ra);
         else drive(k, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      end
      mem_m[k][8'h20] = 8'hFF;
   endtask

   task automatic test_out_of_range(input int k);
      step_t s [5];
      logic expv;
      s[0] = '{1'b1, 8'hC7, 8'h3C, 8'hFF, 1'b0, 8'h00, 8'h00};
      s[1] = '{1'b1, 8'hC8, 8'h77, 8'hFF, 1'b0, 8'h00, 8'h00};
      s[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'hC8, (dep[k] > 200) ? 8'h77 : 8'h00};
      s[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'hC7, 8'h3C};
      s[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
      for (int i = 0; i < 5 + lat[k]; i++) begin
         @(negedge clk);
         expv = 1'b0;
         if (i >= lat[k] && i - lat[k] < 5) begin expv = s[i - lat[k]].re; if (expv) last_d[k] = s[i - lat[k]].ed; end
         n_vec++; if (rd_valid[k] !== expv) begin n_err++; $display("FAIL oor_valid[%0d] step %0d: got %b want %b", k, i, rd_valid[k], expv); end
         n_vec++; if (rd_data[k] !== last_d[k]) begin n_err++; $display("FAIL oor_data[%0d] step %0d: got %h want %h", k, i, rd_data[k], last_d[k]); end
         if (i < 5) drive(k, s[i].we, s[i].wa, s[i].wd, s[i].wm, s[i].re, s[i].ra);
         else drive(k, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      end
      model_wr(k, 8'hC7, 8'h3C, 8'hFF);
      model_wr(k, 8'hC8, 8'h77, 8'hFF);
   endtask

   // clr_i with a same-cycle read, then writes/reads/clr_i hammered while busy.
   task automatic test_clear_drop(input int k);
      int busy_cnt, pulses, cyc; logic seen, done;
      busy_cnt = 0; pulses = 0; cyc = 0; seen = 1'b0; done = 1'b0;
      @(negedge clk); drive(k, 1'b1, 8'h05, 8'h5A, 8'hFF, 1'b0, 8'h00);
      @(negedge clk); drive(k, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h05); clr[k] = 1'b1;
      while (!done && cyc < 700) begin
         @(negedge clk); cyc++;
         if (rd_valid[k]) begin
            pulses++;
            n_vec++; if (rd_data[k] !== 8'h5A) begin n_err++; $display("FAIL clr_preread[%0d]: got %h want 5a", k, rd_data[k]); end
         end
         if (cyc == 1) begin
            n_vec++; if (busy[k] !== 1'b1) begin n_err++; $display("FAIL clr_start[%0d]: got %b want 1", k, busy[k]); end
         end
         if (busy[k]) begin seen = 1'b1; busy_cnt++; end
         else if (seen) done = 1'b1;
         if (done) begin drive(k, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00); clr[k] = 1'b0; end
         else begin drive(k, 1'b1, 8'h05, 8'h33, 8'hFF, 1'b1, 8'h05); clr[k] = 1'b1; end
      end
      clr[k] = 1'b0;
      n_vec++; if (!done) begin n_err++; $display("FAIL clr_timeout[%0d]: busy never completed", k); end
      n_vec++; if (busy_cnt != dep[k]) begin n_err++; $display("FAIL clr_len[%0d]: busy %0d cycles want %0d", k, busy_cnt, dep[k]); end
      n_vec++; if (pulses != 1) begin n_err++; $display("FAIL clr_pulses[%0d]: got %0d want 1", k, pulses); end
      model_zero(k);
      last_d[k] = 8'h5A;
   endtask

   task automatic test_reset_midclear();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (101) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_vec++; if (busy[k] !== 1'b1) begin n_err++; $display("FAIL mid_busy[%0d]: got %b want 1", k, busy[k]); end
      end
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_vec++; if (busy[k] !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy[%0d]: got %b want 0", k, busy[k]); end
         n_vec++; if (rd_data[k] !== 8'h00) begin n_err++; $display("FAIL mid_rst_data[%0d]: got %h want 00", k, rd_data[k]); end
         last_d[k] = 8'h00;
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      test_clear_timing("restart");
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clear_timing("por");
      for (int k = 0; k < 2; k++) test_stream(k, 0, 256);
      for (int k = 0; k < 2; k++) begin
         test_write_read(k);
         test_rdw(k);
         test_out_of_range(k);
      end
      for (int k = 0; k < 2; k++) test_stream(k, 1, 300);
      for (int k = 0; k < 2; k++) begin
         test_clear_drop(k);
         test_stream(k, 0, 256);
      end
      test_reset_midclear();
      for (int k = 0; k < 2; k++) test_stream(k, 0, 256);
      for (int k = 0; k < 2; k++) test_stream(k, 1, 150);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
